imm_gen_stage: RTL

//  Parametrised, registered immediate generator for the decode stage of the RISC-V core.

---
 rtl/imm_gen_stage.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/imm_gen_stage.sv
// Registered RISC-V immediate generator with PC-relative target, 2-entry skid buffer,
// flush, and a saturating count of illegal ImmSrc codes.
module imm_gen_stage #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          instruction,
    input  logic [2:0]           ImmSrc,
    input  logic [XLEN-1:0]      PC,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      ImmBits,
    output logic [XLEN-1:0]      Target,
    output logic                 ImmErr,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic [2:0] {
        SRC_I = 3'b000,
        SRC_S = 3'b001,
        SRC_B = 3'b010,
        SRC_J = 3'b011,
        SRC_U = 3'b100
    } imm_src_e;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] tgt;
        logic            err;
    } entry_t;

    occ_e                 occ_q, occ_d;
    entry_t               head_q, head_d;
    entry_t               tail_q, tail_d;
    logic                 in_ready_q, in_ready_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [31:0] imm32;
    logic        dec_err;
    entry_t      dec;
    logic        push, pop;

    // All formats are built as 32-bit values and then sign-extended from bit 31,
    // which gives RV64 semantics for U as well.
    always_comb begin
        imm32   = '0;
        dec_err = 1'b0;
        case (ImmSrc)
            SRC_I:   imm32 = {{20{instruction[31]}}, instruction[31:20]};
            SRC_S:   imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
            SRC_B:   imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                              instruction[30:25], instruction[11:8], 1'b0};
            SRC_J:   imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                              instruction[20], instruction[30:21], 1'b0};
            SRC_U:   imm32 = {instruction[31:12], 12'b0};
            default: dec_err = 1'b1;
        endcase
        dec.imm = XLEN'($signed(imm32));
        dec.tgt = PC + dec.imm;
        dec.err = dec_err;
    end

    assign push = in_valid & in_ready_q & ~flush;
    assign pop  = (occ_q != OCC_EMPTY) & out_ready;

    always_comb begin
        occ_d     = occ_q;
        head_d    = head_q;
        tail_d    = tail_q;
        err_cnt_d = err_cnt_q;
        case (occ_q)
            OCC_EMPTY: begin
                if (push) begin
                    head_d = dec;
                    occ_d  = OCC_ONE;
                end
            end
            OCC_ONE: begin
                case ({push, pop})
                    2'b10: begin
                        tail_d = dec;
                        occ_d  = OCC_TWO;
                    end
                    2'b01: occ_d = OCC_EMPTY;
                    2'b11: head_d = dec;
                    default: ;
                endcase
            end
            OCC_TWO: begin
                // in_ready was low, so only a pop can happen here
                if (pop) begin
                    head_d = tail_q;
                    occ_d  = OCC_ONE;
                end
            end
            default: occ_d = OCC_EMPTY;
        endcase
        if (flush) begin
            occ_d = OCC_EMPTY;
        end
        in_ready_d = (occ_d != OCC_TWO);
        if (push && dec.err && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q      <= OCC_EMPTY;
            head_q     <= '0;
            tail_q     <= '0;
            in_ready_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            occ_q      <= occ_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            in_ready_q <= in_ready_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (occ_q != OCC_EMPTY);
    assign ImmBits   = head_q.imm;
    assign Target    = head_q.tgt;
    assign ImmErr    = head_q.err;
    assign err_count = err_cnt_q;

endmodule
